// File: rtl/sync_fwft_fifo.sv
// sync_fwft_fifo: single-clock first-word-fall-through FIFO.
// Storage is a DEPTH-entry array with a registered read port. That read
// register is the output register, so a storage read lands in rdata_o on
// the edge that issues it, and no separate in-flight stage exists.
// The count covers storage plus the output register.
// Optional feature: define SYNC_FWFT_FIFO_BYPASS_EN to let a write into an
// empty FIFO load the output register directly, which removes one cycle of
// latency. Count, ordering, capacity and flags are the same in both builds.
module sync_fwft_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int LOG_DEPTH  = 4,
    parameter int AF_THRESH  = (2**LOG_DEPTH) - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  wvalid_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  wready_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    input  logic                  rready_i,
    output logic [LOG_DEPTH:0]    fifo_cnt_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o
);

    localparam int                 DEPTH    = 2**LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] FULL_CNT = (LOG_DEPTH+1)'(DEPTH);
    localparam logic [LOG_DEPTH:0] AF_LVL   = (LOG_DEPTH+1)'(AF_THRESH);
    localparam logic [LOG_DEPTH:0] AE_LVL   = (LOG_DEPTH+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LOG_DEPTH-1:0]  wptr;
    logic [LOG_DEPTH-1:0]  rptr;
    logic [LOG_DEPTH:0]    cnt;
    logic                  rvalid_q;

    logic                  wr_fire;
    logic                  rd_fire;
    logic                  out_free;
    logic [LOG_DEPTH:0]    mem_cnt;
    logic                  mem_empty;
    logic                  rd_issue;
    logic                  byp_take;
    logic                  mem_wr;

    // Handshakes, storage occupancy and the read/bypass decisions for this cycle.
    // NOTE: every signal is assigned on every pass through this block, so no latch can be inferred.
    always_comb begin
        wready_o  = (cnt != FULL_CNT) && !flush_i;
        wr_fire   = wvalid_i && wready_o;
        rd_fire   = rvalid_q && rready_i;
        // The output register can take new data if it is empty or is being popped now.
        out_free  = !rvalid_q || rd_fire;
        // Entries in the array are the total count minus the one held at the output.
        mem_cnt   = cnt - (LOG_DEPTH+1)'(rvalid_q);
        mem_empty = (mem_cnt == '0);
        rd_issue  = !mem_empty && out_free && !flush_i;
`ifdef SYNC_FWFT_FIFO_BYPASS_EN
        // Nothing older is queued, so the word can go straight to the output.
        byp_take  = wr_fire && mem_empty && out_free;
`else
        byp_take  = 1'b0;
`endif
        mem_wr    = wr_fire && !byp_take;
    end

    // Pointers, occupancy count and output-valid; a flush clears all of them and wins over handshakes.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            rvalid_q <= 1'b0;
        end else if (flush_i) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (mem_wr)   wptr <= wptr + LOG_DEPTH'(1);
            if (rd_issue) rptr <= rptr + LOG_DEPTH'(1);
            if (out_free) rvalid_q <= rd_issue || byp_take;
            case ({wr_fire, rd_fire})
                2'b10:   cnt <= cnt + (LOG_DEPTH+1)'(1);
                2'b01:   cnt <= cnt - (LOG_DEPTH+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Array write port and registered read port, which doubles as the output data register.
    // NOTE: the array and its read register have no reset; rvalid_o guards every use of their contents.
    always_ff @(posedge clk) begin
        if (mem_wr) mem[wptr] <= wdata_i;
        if (rd_issue)      rdata_o <= mem[rptr];
        else if (byp_take) rdata_o <= wdata_i;
    end

    assign rvalid_o       = rvalid_q;
    assign fifo_cnt_o     = cnt;
    assign almost_full_o  = (cnt >= AF_LVL);
    assign almost_empty_o = (cnt <= AE_LVL);

endmodule

// File: tb/tb_sync_fwft_fifo.sv
// tb_sync_fwft_fifo: directed self-checking bench for sync_fwft_fifo
// with default parameters (DEPTH 16, AF 15, AE 1).
module tb_sync_fwft_fifo;

`ifdef SYNC_FWFT_FIFO_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        wvalid_i;
    logic [31:0] wdata_i;
    logic        wready_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        rready_i;
    logic [4:0]  fifo_cnt_o;
    logic        almost_full_o;
    logic        almost_empty_o;

    int checks = 0;
    int errors = 0;
    int rd_n;

    sync_fwft_fifo dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .wvalid_i       (wvalid_i),
        .wdata_i        (wdata_i),
        .wready_o       (wready_o),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .rready_i       (rready_i),
        .fifo_cnt_o     (fifo_cnt_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; wvalid_i = 1'b0; wdata_i = '0; rready_i = 1'b0;
        #1;
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_cnt",    32'(fifo_cnt_o), 32'd0);
        check("rst_wready", 32'(wready_o), 32'd1);
        check("rst_ae",     32'(almost_empty_o), 32'd1);
        check("rst_af",     32'(almost_full_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // First word latency into an empty FIFO.
        wvalid_i = 1'b1; wdata_i = 32'hA5A5_0001;
        tick();
        wvalid_i = 1'b0;
        check("lat_cnt", 32'(fifo_cnt_o), 32'd1);
        check("lat_rvalid_e0", 32'(rvalid_o), (LAT == 1) ? 32'd1 : 32'd0);
        if (LAT == 2) tick();
        check("lat_rvalid", 32'(rvalid_o), 32'd1);
        check("lat_rdata",  rdata_o, 32'hA5A5_0001);
        tick();
        check("lat_hold",   rdata_o, 32'hA5A5_0001);
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
        check("pop1_cnt",    32'(fifo_cnt_o), 32'd0);
        check("pop1_rvalid", 32'(rvalid_o), 32'd0);

        // Fill to capacity with 0..15.
        for (int i = 0; i < 16; i++) begin
            check("fill_wready", 32'(wready_o), 32'd1);
            wvalid_i = 1'b1; wdata_i = 32'(i);
            tick();
            check("fill_cnt", 32'(fifo_cnt_o), 32'(i + 1));
            check("fill_af",  32'(almost_full_o), (i + 1 >= 15) ? 32'd1 : 32'd0);
            check("fill_ae",  32'(almost_empty_o), (i + 1 <= 1) ? 32'd1 : 32'd0);
        end
        check("full_wready", 32'(wready_o), 32'd0);
        check("full_head",   rdata_o, 32'd0);
        wdata_i = 32'd99;
        tick();
        check("full_refuse_cnt", 32'(fifo_cnt_o), 32'd16);

        // Pop and write together while full: write refused, accepted next cycle.
        wdata_i = 32'd16; rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
        check("fullrw_cnt",    32'(fifo_cnt_o), 32'd15);
        check("fullrw_head",   rdata_o, 32'd1);
        check("fullrw_wready", 32'(wready_o), 32'd1);
        tick();
        wvalid_i = 1'b0;
        check("fullrw_refill", 32'(fifo_cnt_o), 32'd16);

        // Drain: expect 1..16.
        rready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_rvalid", 32'(rvalid_o), 32'd1);
            check("drain_data",   rdata_o, 32'(i + 1));
            tick();
        end
        rready_i = 1'b0;
        check("drain_cnt",    32'(fifo_cnt_o), 32'd0);
        check("drain_rvalid_end", 32'(rvalid_o), 32'd0);
        check("drain_ae",     32'(almost_empty_o), 32'd1);

        // Streaming 40 words at one per cycle across two pointer wraps.
        rd_n = 0;
        rready_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wvalid_i = 1'b1; wdata_i = 32'(1000 + i);
            if (i >= LAT) begin
                check("stream_rvalid", 32'(rvalid_o), 32'd1);
                check("stream_cnt",    32'(fifo_cnt_o), 32'(LAT));
            end
            if (rvalid_o) begin
                check("stream_data", rdata_o, 32'(1000 + rd_n));
                rd_n++;
            end
            tick();
        end
        wvalid_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (rvalid_o) begin
                check("stream_data", rdata_o, 32'(1000 + rd_n));
                rd_n++;
            end
            tick();
        end
        rready_i = 1'b0;
        check("stream_total", 32'(rd_n), 32'd40);
        check("stream_cnt_end", 32'(fifo_cnt_o), 32'd0);

        // Flush with 5 held and a write presented in the flush cycle.
        for (int i = 0; i < 5; i++) begin
            wvalid_i = 1'b1; wdata_i = 32'h100 + 32'(i);
            tick();
        end
        check("preflush_cnt", 32'(fifo_cnt_o), 32'd5);
        flush_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        #1;
        check("flush_wready", 32'(wready_o), 32'd0);
        tick();
        flush_i = 1'b0; wvalid_i = 1'b0;
        check("flush_rvalid", 32'(rvalid_o), 32'd0);
        check("flush_cnt",    32'(fifo_cnt_o), 32'd0);
        check("flush_ae",     32'(almost_empty_o), 32'd1);
        tick();
        check("flush_nodrop_cnt", 32'(fifo_cnt_o), 32'd0);
        wvalid_i = 1'b1; wdata_i = 32'h200;
        tick();
        wvalid_i = 1'b0;
        if (LAT == 2) tick();
        check("postflush_rvalid", 32'(rvalid_o), 32'd1);
        check("postflush_data",   rdata_o, 32'h200);
        check("postflush_cnt",    32'(fifo_cnt_o), 32'd1);

        // Asynchronous reset mid-stream at count 7.
        for (int i = 0; i < 6; i++) begin
            wvalid_i = 1'b1; wdata_i = 32'h300 + 32'(i);
            tick();
        end
        wvalid_i = 1'b0;
        check("prerst_cnt", 32'(fifo_cnt_o), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rvalid", 32'(rvalid_o), 32'd0);
        check("arst_cnt",    32'(fifo_cnt_o), 32'd0);
        check("arst_wready", 32'(wready_o), 32'd1);
        check("arst_ae",     32'(almost_empty_o), 32'd1);
        check("arst_af",     32'(almost_full_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        wvalid_i = 1'b1; wdata_i = 32'hCAFE_F00D;
        tick();
        wvalid_i = 1'b0;
        if (LAT == 2) tick();
        check("postrst_rvalid", 32'(rvalid_o), 32'd1);
        check("postrst_data",   rdata_o, 32'hCAFE_F00D);
        check("postrst_cnt",    32'(fifo_cnt_o), 32'd1);
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
        check("postrst_empty", 32'(rvalid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
